// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with a live terminal value, a synchronous
// parallel load, validity flags and a one-cycle wrap pulse for cascading.
module bcd_updown_counter #(
    parameter int DIGITS = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                up_dn,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    input  logic [4*DIGITS-1:0] max_val,
    output logic [4*DIGITS-1:0] count,
    output logic                wrap,
    output logic                load_err,
    output logic                cfg_err
);

    localparam int W = 4 * DIGITS;

    logic [W-1:0]      r_count;
    logic              r_wrap;
    logic              r_load_err;

    logic [W-1:0]      w_inc;
    logic [W-1:0]      w_dec;
    logic [DIGITS-1:0] w_carry;
    logic [DIGITS-1:0] w_borrow;
    logic [DIGITS-1:0] w_max_bad;
    logic [DIGITS-1:0] w_ld_bad;
    logic              w_cfg_err;
    logic              w_ld_ok;
    logic              w_at_max;
    logic              w_over_max;
    logic              w_is_zero;

    // BCD magnitude a > b, decided by the most significant differing digit
    function automatic logic bcd_gt(input logic [W-1:0] a, input logic [W-1:0] b);
        logic decided;
        logic gt;
        decided = 1'b0;
        gt      = 1'b0;
        for (int unsigned i = DIGITS; i > 0; i--) begin
            if (!decided && (a[4*(i-1) +: 4] != b[4*(i-1) +: 4])) begin
                decided = 1'b1;
                gt      = (a[4*(i-1) +: 4] > b[4*(i-1) +: 4]);
            end
        end
        return gt;
    endfunction

    assign w_carry[0]  = 1'b1;
    assign w_borrow[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        logic [3:0] w_d;
        assign w_d = r_count[4*g +: 4];

        // A digit only moves when everything below it rolled over
        assign w_inc[4*g +: 4] = !w_carry[g]  ? w_d : ((w_d == 4'd9) ? 4'd0 : w_d + 4'd1);
        assign w_dec[4*g +: 4] = !w_borrow[g] ? w_d : ((w_d == 4'd0) ? 4'd9 : w_d - 4'd1);

        assign w_max_bad[g] = (max_val[4*g +: 4]  > 4'd9);
        assign w_ld_bad[g]  = (load_val[4*g +: 4] > 4'd9);

        if (g < DIGITS - 1) begin : g_chain
            assign w_carry[g+1]  = w_carry[g]  & (w_d == 4'd9);
            assign w_borrow[g+1] = w_borrow[g] & (w_d == 4'd0);
        end
    end

    assign w_cfg_err  = |w_max_bad;
    assign w_ld_ok    = !(|w_ld_bad) && !w_cfg_err && !bcd_gt(load_val, max_val);
    assign w_at_max   = !bcd_gt(max_val, r_count);
    assign w_over_max = bcd_gt(r_count, max_val);
    assign w_is_zero  = (r_count == '0);

    // Count, wrap pulse and sticky load error; priority is load, then step, then hold
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count    <= '0;
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else if (load) begin
            r_wrap <= 1'b0;
            if (w_ld_ok) begin
                r_count    <= load_val;
                r_load_err <= 1'b0;
            end else begin
                r_load_err <= 1'b1;
            end
        end else if (en && !w_cfg_err) begin
            if (up_dn) begin
                if (w_at_max) begin
                    r_count <= '0;
                    r_wrap  <= 1'b1;
                end else begin
                    r_count <= w_inc;
                    r_wrap  <= 1'b0;
                end
            end else if (w_is_zero) begin
                r_count <= max_val;
                r_wrap  <= 1'b1;
            end else if (w_over_max) begin
                // max_val was lowered below the count: clamp without a wrap pulse
                r_count <= max_val;
                r_wrap  <= 1'b0;
            end else begin
                r_count <= w_dec;
                r_wrap  <= 1'b0;
            end
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign count    = r_count;
    assign wrap     = r_wrap;
    assign load_err = r_load_err;
    assign cfg_err  = w_cfg_err;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter: a 2-digit and a 4-digit instance,
// hand-computed expected values, one checking task.
module tb_bcd_updown_counter;

    logic        clk;
    logic        reset;

    logic        d2_en, d2_up_dn, d2_load;
    logic [7:0]  d2_load_val, d2_max_val, d2_count;
    logic        d2_wrap, d2_load_err, d2_cfg_err;

    logic        d4_en, d4_up_dn, d4_load;
    logic [15:0] d4_load_val, d4_max_val, d4_count;
    logic        d4_wrap, d4_load_err, d4_cfg_err;

    int n_vec;
    int n_bad;

    bcd_updown_counter #(.DIGITS(2)) u_dut2 (
        .clk(clk), .reset(reset), .en(d2_en), .up_dn(d2_up_dn), .load(d2_load),
        .load_val(d2_load_val), .max_val(d2_max_val), .count(d2_count),
        .wrap(d2_wrap), .load_err(d2_load_err), .cfg_err(d2_cfg_err)
    );

    bcd_updown_counter #(.DIGITS(4)) u_dut4 (
        .clk(clk), .reset(reset), .en(d4_en), .up_dn(d4_up_dn), .load(d4_load),
        .load_val(d4_load_val), .max_val(d4_max_val), .count(d4_count),
        .wrap(d4_wrap), .load_err(d4_load_err), .cfg_err(d4_cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] to_bcd(input int n);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(n / 10);
        lo = 4'(n % 10);
        return {hi, lo};
    endfunction

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset = 1'b0;
        d2_en = 1'b0; d2_up_dn = 1'b1; d2_load = 1'b0; d2_load_val = 8'h00; d2_max_val = 8'h59;
        d4_en = 1'b0; d4_up_dn = 1'b1; d4_load = 1'b0; d4_load_val = 16'h0; d4_max_val = 16'h9999;

        // 1. reset, then count up through 00..59 and wrap
        #12;
        chk("rst_count", 32'(d2_count), 32'h00);
        chk("rst_wrap", 32'(d2_wrap), 32'h0);
        chk("rst_lerr", 32'(d2_load_err), 32'h0);
        chk("rst_cfg", 32'(d2_cfg_err), 32'h0);
        chk("rst_count4", 32'(d4_count), 32'h0000);
        @(negedge clk);
        reset = 1'b1;
        d2_en = 1'b1;
        step();
        for (int i = 1; i <= 60; i++) begin
            chk("up_count", 32'(d2_count), 32'(to_bcd(i % 60)));
            chk("up_wrap", 32'(d2_wrap), (i == 60) ? 32'h1 : 32'h0);
            step();
        end
        // one extra step above: 00 -> 01, wrap drops
        chk("up_after_wrap", 32'(d2_count), 32'h01);
        chk("up_wrap_drop", 32'(d2_wrap), 32'h0);

        // 2. down wrap from 00 to 23 and count down through the 10->09 borrow
        d2_en = 1'b0; d2_load = 1'b1; d2_load_val = 8'h00;
        step();
        chk("ld00", 32'(d2_count), 32'h00);
        d2_load = 1'b0; d2_en = 1'b1; d2_up_dn = 1'b0; d2_max_val = 8'h23;
        step();
        chk("dn_wrap_count", 32'(d2_count), 32'h23);
        chk("dn_wrap", 32'(d2_wrap), 32'h1);
        for (int k = 22; k >= 9; k--) begin
            step();
            chk("dn_count", 32'(d2_count), 32'(to_bcd(k)));
            chk("dn_wrap0", 32'(d2_wrap), 32'h0);
        end

        // 3. load checks (count is 09 here)
        d2_en = 1'b0; d2_load = 1'b1; d2_load_val = 8'h1A; d2_max_val = 8'h59;
        step();
        chk("ld1A_count", 32'(d2_count), 32'h09);
        chk("ld1A_err", 32'(d2_load_err), 32'h1);
        d2_load_val = 8'h42;
        step();
        chk("ld42_count", 32'(d2_count), 32'h42);
        chk("ld42_err", 32'(d2_load_err), 32'h0);
        d2_load_val = 8'h60;
        step();
        chk("ld60_count", 32'(d2_count), 32'h42);
        chk("ld60_err", 32'(d2_load_err), 32'h1);
        d2_load_val = 8'h59;
        step();
        chk("ld59_edge", 32'(d2_count), 32'h59);
        chk("ld59_err", 32'(d2_load_err), 32'h0);
        d2_en = 1'b1; d2_up_dn = 1'b1; d2_load_val = 8'h15;
        step();
        chk("ld_wins", 32'(d2_count), 32'h15);
        chk("ld_wins_wrap", 32'(d2_wrap), 32'h0);

        // 4. live max_val changes and invalid configuration
        d2_en = 1'b0; d2_load_val = 8'h45;
        step();
        d2_load = 1'b0; d2_en = 1'b1; d2_up_dn = 1'b1; d2_max_val = 8'h30;
        step();
        chk("live_up_count", 32'(d2_count), 32'h00);
        chk("live_up_wrap", 32'(d2_wrap), 32'h1);
        d2_en = 1'b0; d2_load = 1'b1; d2_max_val = 8'h59;
        step();
        d2_load = 1'b0; d2_en = 1'b1; d2_up_dn = 1'b0; d2_max_val = 8'h30;
        step();
        chk("live_dn_count", 32'(d2_count), 32'h30);
        chk("live_dn_wrap", 32'(d2_wrap), 32'h0);
        d2_max_val = 8'h5F;
        #1;
        chk("cfg_err", 32'(d2_cfg_err), 32'h1);
        step();
        chk("cfg_hold", 32'(d2_count), 32'h30);
        d2_en = 1'b0; d2_load = 1'b1; d2_load_val = 8'h10;
        step();
        chk("cfg_ld_count", 32'(d2_count), 32'h30);
        chk("cfg_ld_err", 32'(d2_load_err), 32'h1);
        d2_load = 1'b0; d2_max_val = 8'h59;
        #1;
        chk("cfg_clear", 32'(d2_cfg_err), 32'h0);

        // max_val=0 counting up wraps every cycle
        d2_load = 1'b1; d2_load_val = 8'h00;
        step();
        d2_load = 1'b0; d2_en = 1'b1; d2_up_dn = 1'b1; d2_max_val = 8'h00;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("m0_count", 32'(d2_count), 32'h00);
            chk("m0_wrap", 32'(d2_wrap), 32'h1);
        end

        // 5. async reset between edges at count 37 with wrap and load_err high
        d2_en = 1'b0; d2_load = 1'b1; d2_load_val = 8'h1A; d2_max_val = 8'h37;
        step();
        chk("pre_lerr", 32'(d2_load_err), 32'h1);
        d2_load = 1'b0; d2_en = 1'b1; d2_up_dn = 1'b0;
        step();
        chk("pre_count", 32'(d2_count), 32'h37);
        chk("pre_wrap", 32'(d2_wrap), 32'h1);
        d2_en = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("ares_count", 32'(d2_count), 32'h00);
        chk("ares_wrap", 32'(d2_wrap), 32'h0);
        chk("ares_lerr", 32'(d2_load_err), 32'h0);
        #1 reset = 1'b1;

        // 6. four digits: carry and borrow ripple through every digit
        d4_load = 1'b1; d4_load_val = 16'h9998; d4_max_val = 16'h9999;
        step();
        chk("d4_ld", 32'(d4_count), 32'h9998);
        d4_load = 1'b0; d4_en = 1'b1; d4_up_dn = 1'b1;
        step();
        chk("d4_9999", 32'(d4_count), 32'h9999);
        chk("d4_9999_wrap", 32'(d4_wrap), 32'h0);
        step();
        chk("d4_wrap_count", 32'(d4_count), 32'h0000);
        chk("d4_wrap", 32'(d4_wrap), 32'h1);
        d4_up_dn = 1'b0;
        step();
        chk("d4_dn_count", 32'(d4_count), 32'h9999);
        chk("d4_dn_wrap", 32'(d4_wrap), 32'h1);
        d4_en = 1'b0; d4_load = 1'b1; d4_load_val = 16'h1000;
        step();
        d4_load = 1'b0; d4_en = 1'b1;
        step();
        chk("d4_borrow", 32'(d4_count), 32'h0999);
        d4_up_dn = 1'b1;
        step();
        chk("d4_carry", 32'(d4_count), 32'h1000);
        chk("d4_carry_wrap", 32'(d4_wrap), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
